// File: rtl/sr_latch_driver_if.sv
// Request handshake between control logic and sr_latch_driver.
// The master presents a target latch level; the slave signals when it can take it.
interface sr_latch_driver_if;
    logic req_valid;
    logic req_level;
    logic req_ready;

    modport master (
        output req_valid,
        output req_level,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_level,
        output req_ready
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Turns "set latch to level L" requests into exclusive, fixed-width s/r pulses
// with a recovery gap, and tracks a shadow copy of the latch output.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_latch_driver_if.slave     bus,
    output logic                 s,
    output logic                 r,
    output logic                 q_model,
    output logic                 known,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          accept;
    logic          redundant;

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    // Until the first pulse the real latch may hold anything, so never skip.
    assign redundant     = known & (bus.req_level == q_model);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            lvl     <= 1'b0;
            s       <= 1'b0;
            r       <= 1'b0;
            q_model <= 1'b0;
            known   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (redundant) begin
                            done <= 1'b1;
                        end else begin
                            state <= PULSE;
                            cnt   <= PULSE_LD;
                            lvl   <= bus.req_level;
                            s     <= bus.req_level;
                            r     <= ~bus.req_level;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        s       <= 1'b0;
                        r       <= 1'b0;
                        q_model <= lvl;
                        known   <= 1'b1;
                        if (GAP_W == 0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                end
            endcase
        end
    end

    a_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(s && r));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Two driver instances (PULSE_W=2/GAP_W=1 and PULSE_W=1/GAP_W=0) share random
// requests and are compared cycle by cycle against a timeline-based model.
module tb_sr_latch_driver;

    localparam int P0 = 2;
    localparam int G0 = 1;
    localparam int P1 = 1;
    localparam int G1 = 0;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       level;
    logic [1:0] s_o, r_o, q_o, k_o, d_o, rdy;
    logic       lq0, lq1;

    int n;
    int n_vec;
    int n_err;

    typedef struct {
        int acc;
        int done_cyc;
        int busy_end;
        bit pulsing;
        bit lvl;
        bit q;
        bit known;
    } mdl_t;

    mdl_t m [2];

    sr_latch_driver_if bus0 ();
    sr_latch_driver_if bus1 ();

    assign bus0.req_valid = valid;
    assign bus0.req_level = level;
    assign bus1.req_valid = valid;
    assign bus1.req_level = level;
    assign rdy[0] = bus0.req_ready;
    assign rdy[1] = bus1.req_ready;

    sr_latch_driver #(.PULSE_W(P0), .GAP_W(G0), .CW(4)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .s(s_o[0]), .r(r_o[0]), .q_model(q_o[0]), .known(k_o[0]), .done(d_o[0])
    );

    sr_latch_driver #(.PULSE_W(P1), .GAP_W(G1), .CW(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .s(s_o[1]), .r(r_o[1]), .q_model(q_o[1]), .known(k_o[1]), .done(d_o[1])
    );

    // Behavioural gated SR latch with its gate tied high.
    always @(posedge s_o[0]) lq0 <= 1'b1;
    always @(posedge r_o[0]) lq0 <= 1'b0;
    always @(posedge s_o[1]) lq1 <= 1'b1;
    always @(posedge r_o[1]) lq1 <= 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) n <= n + 1;

    function automatic int pw(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    function automatic int gw(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    function automatic bit committed(input int i);
        return m[i].pulsing && (n >= m[i].acc + pw(i));
    endfunction

    function automatic bit q_e(input int i);
        return committed(i) ? m[i].lvl : m[i].q;
    endfunction

    function automatic bit known_e(input int i);
        return committed(i) ? 1'b1 : m[i].known;
    endfunction

    function automatic bit in_pulse(input int i);
        return m[i].pulsing && (n >= m[i].acc) && (n < m[i].acc + pw(i));
    endfunction

    function automatic bit lq(input int i);
        return (i == 0) ? lq0 : lq1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].acc      = 0;
            m[i].done_cyc = -1;
            m[i].busy_end = 0;
            m[i].pulsing  = 1'b0;
            m[i].lvl      = 1'b0;
            m[i].q        = 1'b0;
            m[i].known    = 1'b0;
        end
    endtask

    task automatic model_accept(input int i, input bit l);
        int a;
        bit qq, kk;
        a  = n + 1;
        qq = q_e(i);
        kk = known_e(i);
        m[i].q     = qq;
        m[i].known = kk;
        if (kk && (l == qq)) begin
            m[i].pulsing  = 1'b0;
            m[i].done_cyc = a;
        end else begin
            m[i].pulsing  = 1'b1;
            m[i].acc      = a;
            m[i].lvl      = l;
            m[i].busy_end = a + pw(i) + gw(i);
            m[i].done_cyc = m[i].busy_end;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.req_ready", i), rdy[i],  n >= m[i].busy_end);
            chk($sformatf("u%0d.s", i),         s_o[i],  in_pulse(i) && m[i].lvl);
            chk($sformatf("u%0d.r", i),         r_o[i],  in_pulse(i) && !m[i].lvl);
            chk($sformatf("u%0d.done", i),      d_o[i],  n == m[i].done_cyc);
            chk($sformatf("u%0d.known", i),     k_o[i],  known_e(i));
            chk($sformatf("u%0d.q_model", i),   q_o[i],  q_e(i));
            chk($sformatf("u%0d.s_and_r", i),   s_o[i] & r_o[i], 1'b0);
            if (known_e(i) && (n >= m[i].busy_end))
                chk($sformatf("u%0d.latch_q", i), lq(i), q_e(i));
        end
    endtask

    // Called at a falling edge: check this cycle, then present next request.
    task automatic step(input bit v, input bit l);
        check_outputs();
        valid = v;
        level = l;
        if (v) begin
            for (int i = 0; i < 2; i++)
                if (n >= m[i].busy_end) model_accept(i, l);
        end
    endtask

    bit [1:0] seq [16] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                           2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                           2'b11, 2'b10, 2'b11, 2'b10};

    initial begin
        bit hit;
        n     = 0;
        n_vec = 0;
        n_err = 0;
        lq0   = 1'b0;
        lq1   = 1'b0;
        valid = 1'b0;
        level = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0);

        foreach (seq[j]) begin
            @(negedge clk);
            step(seq[j][1], seq[j][0]);
        end

        // Drive requests until u0 is in the first cycle of a pulse, then reset.
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m[0].pulsing && (n == m[0].acc)) begin
                hit = 1'b1;
                break;
            end
            step(1'b1, 1'($urandom_range(0, 1)));
        end
        chk("reach_pulse", hit, 1'b1);
        chk("pre_reset_pulse", s_o[0] | r_o[0], 1'b1);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.rst_s", i),       s_o[i], 1'b0);
            chk($sformatf("u%0d.rst_r", i),       r_o[i], 1'b0);
            chk($sformatf("u%0d.rst_done", i),    d_o[i], 1'b0);
            chk($sformatf("u%0d.rst_known", i),   k_o[i], 1'b0);
            chk($sformatf("u%0d.rst_q_model", i), q_o[i], 1'b0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0);
        @(negedge clk);
        chk("post_reset_r_pulse", r_o[0], 1'b1);
        step(1'b0, 1'b0);

        repeat (500) begin
            @(negedge clk);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end
        repeat (6) begin
            @(negedge clk);
            step(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
